// File: rtl/set_arbiter_pkg.sv
// set_arbiter_pkg: shared state encoding, mode constants and operand widths for the set-count arbiter
// Contents: state_t (arbiter FSM), MODE_* set operations, *_W operand widths, port_oh one-hot helper.
package set_arbiter_pkg;
  localparam int CENT_W = 24;
  localparam int RAD_W  = 12;
  localparam int MODE_W = 2;
  localparam int RES_W  = 8;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_FINISH} state_t;
  localparam logic [MODE_W-1:0] MODE_A   = 2'b00;
  localparam logic [MODE_W-1:0] MODE_AND = 2'b01;
  localparam logic [MODE_W-1:0] MODE_XOR = 2'b10;
  localparam logic [MODE_W-1:0] MODE_ILL = 2'b11;
  function automatic logic [1:0] port_oh(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/set_rr_pick.sv
// set_rr_pick: two-way round-robin selector with its own priority pointer
// Ports: clk/rst (async active-high), i_req {req1,req0}, i_adv (a grant is taken this cycle),
//        o_sel (winning port), o_any (some port is requesting).
module set_rr_pick (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic       o_sel,
  output logic       o_any
);
  logic r_ptr;
  assign o_any = |i_req;
  assign o_sel = &i_req ? r_ptr : i_req[1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= ~o_sel;
  end
endmodule

// File: rtl/set_arbiter.sv
// set_arbiter: arbitrates two requesters onto one shared set-count engine
// Ports: req*/central*/radius*/mode* job requests, gnt*/done*/result*/err job handshake,
//        eng_en/eng_central/eng_radius/eng_mode engine start and operands,
//        eng_busy/eng_valid/eng_candidate engine status. clk, rst async active-high.
module set_arbiter
  import set_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [CENT_W-1:0] central0,
  input  logic [CENT_W-1:0] central1,
  input  logic [RAD_W-1:0]  radius0,
  input  logic [RAD_W-1:0]  radius1,
  input  logic [MODE_W-1:0] mode0,
  input  logic [MODE_W-1:0] mode1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [RES_W-1:0]  result0,
  output logic [RES_W-1:0]  result1,
  output logic              err,
  output logic              eng_en,
  output logic [CENT_W-1:0] eng_central,
  output logic [RAD_W-1:0]  eng_radius,
  output logic [MODE_W-1:0] eng_mode,
  input  logic              eng_busy,
  input  logic              eng_valid,
  input  logic [RES_W-1:0]  eng_candidate
);
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 7) ? $clog2(TIMEOUT + 1) : 7;
  state_t r_state;
  logic r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic w_sel, w_any, w_take;
  logic [MODE_W-1:0] w_mode;
  assign w_take = (r_state == S_IDLE) && !eng_busy && w_any;
  assign w_mode = w_sel ? mode1 : mode0;
  set_rr_pick u_pick (
    .clk   (clk),
    .rst   (rst),
    .i_req ({req1, req0}),
    .i_adv (w_take),
    .o_sel (w_sel),
    .o_any (w_any)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_cnt       <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err         <= 1'b0;
      eng_en      <= 1'b0;
      result0     <= '0;
      result1     <= '0;
      eng_central <= '0;
      eng_radius  <= '0;
      eng_mode    <= '0;
    end else begin
      {gnt1, gnt0}   <= 2'b00;
      {done1, done0} <= 2'b00;
      err            <= 1'b0;
      eng_en         <= 1'b0;
      case (r_state)
        S_IDLE: if (w_take) begin
          r_sel        <= w_sel;
          {gnt1, gnt0} <= port_oh(w_sel);
          r_state      <= S_ISSUE;
          // illegal mode never reaches the engine; the job completes inside ISSUE
          if (w_mode == MODE_ILL) begin
            {done1, done0} <= port_oh(w_sel);
            err            <= 1'b1;
            if (w_sel) result1 <= '0;
            else result0 <= '0;
          end else begin
            eng_en      <= 1'b1;
            eng_central <= w_sel ? central1 : central0;
            eng_radius  <= w_sel ? radius1 : radius0;
            eng_mode    <= w_mode;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= eng_en ? S_RUN : S_IDLE;
        end
        // eng_valid wins over a timeout landing in the same cycle
        S_RUN: if (eng_valid || r_cnt == CNT_W'(TIMEOUT - 1)) begin
          {done1, done0} <= port_oh(r_sel);
          err            <= !eng_valid;
          if (r_sel) result1 <= eng_valid ? eng_candidate : '0;
          else result0 <= eng_valid ? eng_candidate : '0;
          r_state <= S_FINISH;
        end else r_cnt <= r_cnt + 1'b1;
        S_FINISH: if (!eng_busy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_arbiter.sv
// tb_set_arbiter: directed, table-driven bench for set_arbiter with a behavioural set-count engine
module tb_set_arbiter;
  import set_arbiter_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [23:0] central0 = '0, central1 = '0;
  logic [11:0] radius0 = '0, radius1 = '0;
  logic [1:0] mode0 = '0, mode1 = '0;
  logic gnt0, gnt1, done0, done1, err, eng_en;
  logic [7:0] result0, result1;
  logic [23:0] eng_central;
  logic [11:0] eng_radius;
  logic [1:0] eng_mode;
  logic eng_busy = 1'b0, eng_valid = 1'b0;
  logic [7:0] eng_candidate = '0;
  int checks = 0, errors = 0, cyc = 0, t_gnt = 0, e_cnt = 0, e_lim = 64;
  logic eng_dead = 1'b0, en_seen = 1'b0, unstable = 1'b0;
  logic [23:0] cap_c = '0;
  logic [11:0] cap_r = '0;
  logic [1:0] cap_m = '0;
  logic [7:0] exp_r0 = '0, exp_r1 = '0;

  localparam logic [23:0] C44 = {4'd4, 4'd4, 4'd5, 4'd4, 8'h00};
  localparam logic [11:0] R22 = {4'd2, 4'd2, 4'd0};

  typedef struct {
    logic        port;
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0]  m;
    logic [7:0]  res;
    logic        e;
    int          lat;
  } vec_t;
  vec_t v[8];

  set_arbiter #(.TIMEOUT(127)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .central0(central0), .central1(central1), .radius0(radius0), .radius1(radius1),
    .mode0(mode0), .mode1(mode1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result0(result0), .result1(result1), .err(err), .eng_en(eng_en),
    .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
    .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // counts 8x8 grid points inside circle A / B combined by the set operation
  function automatic logic [7:0] ref_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int n = 0;
    int xa = c[23:20], ya = c[19:16], xb = c[15:12], yb = c[11:8], ra = r[11:8], rb = r[7:4];
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        logic ia, ib;
        ia = ((x - xa) * (x - xa) + (y - ya) * (y - ya)) <= ra * ra;
        ib = ((x - xb) * (x - xb) + (y - yb) * (y - yb)) <= rb * rb;
        n += (m == MODE_A) ? int'(ia) : (m == MODE_AND) ? int'(ia & ib) : (m == MODE_XOR) ? int'(ia ^ ib) : 0;
      end
    end
    return 8'(n);
  endfunction

  // engine: start on eng_en, valid after e_lim+1 busy cycles, busy lingers 3 more cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_busy <= 1'b0;
      eng_valid <= 1'b0;
      eng_candidate <= '0;
      e_cnt <= 0;
    end else begin
      eng_valid <= 1'b0;
      if (eng_en && !eng_dead) begin
        eng_busy <= 1'b1;
        e_cnt <= 0;
        cap_c <= eng_central;
        cap_r <= eng_radius;
        cap_m <= eng_mode;
      end else if (eng_busy) begin
        e_cnt <= e_cnt + 1;
        if (e_cnt == e_lim) begin
          eng_valid <= 1'b1;
          eng_candidate <= ref_count(eng_central, eng_radius, eng_mode);
        end
        if (e_cnt == e_lim + 3) eng_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk)
    if (eng_busy && {eng_central, eng_radius, eng_mode} != {cap_c, cap_r, cap_m}) unstable <= 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic on, input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    if (port) begin
      req1 = on; central1 = c; radius1 = r; mode1 = m;
    end else begin
      req0 = on; central0 = c; radius0 = r; mode0 = m;
    end
  endtask

  task automatic wait_gnt(input logic port);
    int k = 0;
    while (!(gnt0 | gnt1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("gnt_port", {gnt1, gnt0}, port ? 2 : 1);
    t_gnt = cyc;
    en_seen = eng_en;
  endtask

  task automatic wait_done(input logic port, input logic [7:0] res, input logic e, input logic legal, input int lat);
    int k = 0, extra = 0;
    while (!(done0 | done1) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("done_port", {done1, done0}, port ? 2 : 1);
    chk("result", port ? result1 : result0, res);
    chk("err", err, e);
    chk("latency", cyc - t_gnt, lat);
    chk("eng_en_at_gnt", en_seen, legal);
    if (port) exp_r1 = res;
    else exp_r0 = res;
    chk("other_result_held", port ? result0 : result1, port ? exp_r0 : exp_r1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      extra += int'(done0 | done1);
    end
    chk("single_done", extra, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (eng_busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("engine_idle", eng_busy, 0);
  endtask

  initial begin
    int t0;
    v[0] = '{1'b0, C44, R22, MODE_A, 8'd13, 1'b0, 67};
    v[1] = '{1'b1, C44, R22, MODE_AND, 8'd8, 1'b0, 67};
    v[2] = '{1'b1, C44, R22, MODE_XOR, 8'd10, 1'b0, 67};
    v[3] = '{1'b0, 24'h0, 12'h0, MODE_A, 8'd1, 1'b0, 67};
    v[4] = '{1'b0, 24'h0, {4'd1, 4'd0, 4'd0}, MODE_A, 8'd3, 1'b0, 67};
    v[5] = '{1'b1, {4'd3, 4'd3, 4'd0, 4'd0, 8'h00}, {4'd15, 4'd0, 4'd0}, MODE_A, 8'd64, 1'b0, 67};
    v[6] = '{1'b1, C44, R22, MODE_ILL, 8'd0, 1'b1, 0};
    v[7] = '{1'b0, C44, {4'd2, 4'd0, 4'd0}, MODE_XOR, 8'd12, 1'b0, 67};
    repeat (3) @(negedge clk);
    chk("reset_state", {gnt0, gnt1, done0, done1, err, eng_en, result0, result1, eng_central, eng_radius, eng_mode}, 0);
    rst = 1'b0;
    @(negedge clk);
    // simultaneous requests: port 0 first, port 1 after the engine frees up
    drive(0, 1, C44, R22, MODE_A);
    drive(1, 1, C44, R22, MODE_AND);
    wait_gnt(0);
    t0 = t_gnt;
    drive(0, 0, C44, R22, MODE_A);
    wait_done(0, 8'd13, 0, 1, 67);
    wait_gnt(1);
    chk("rr_gap", t_gnt - t0, 71);
    drive(1, 0, C44, R22, MODE_AND);
    wait_done(1, 8'd8, 0, 1, 67);
    drive(0, 1, C44, R22, MODE_A);
    drive(1, 1, C44, R22, MODE_AND);
    wait_gnt(0);
    drive(0, 0, C44, R22, MODE_A);
    wait_done(0, 8'd13, 0, 1, 67);
    wait_gnt(1);
    drive(1, 0, C44, R22, MODE_AND);
    wait_done(1, 8'd8, 0, 1, 67);
    for (int i = 0; i < 8; i++) begin
      drive(v[i].port, 1, v[i].c, v[i].r, v[i].m);
      wait_gnt(v[i].port);
      drive(v[i].port, 0, v[i].c, v[i].r, v[i].m);
      wait_done(v[i].port, v[i].res, v[i].e, v[i].m != MODE_ILL, v[i].lat);
    end
    // reset in the middle of RUN drops the job and clears every output at once
    drive(0, 1, C44, R22, MODE_XOR);
    wait_gnt(0);
    drive(0, 0, C44, R22, MODE_XOR);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_mid_run", {gnt0, gnt1, done0, done1, err, eng_en, result0, result1, eng_central, eng_radius, eng_mode}, 0);
    exp_r0 = '0;
    exp_r1 = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, C44, R22, MODE_AND);
    wait_gnt(0);
    drive(0, 0, C44, R22, MODE_AND);
    wait_done(0, 8'd8, 0, 1, 67);
    wait_idle();
    // timeouts: silent engine, valid on the timeout cycle, valid one cycle late
    eng_dead = 1'b1;
    drive(0, 1, C44, R22, MODE_A);
    wait_gnt(0);
    drive(0, 0, C44, R22, MODE_A);
    wait_done(0, 8'd0, 1, 1, 128);
    eng_dead = 1'b0;
    e_lim = 125;
    drive(0, 1, C44, R22, MODE_A);
    wait_gnt(0);
    drive(0, 0, C44, R22, MODE_A);
    wait_done(0, 8'd13, 0, 1, 128);
    wait_idle();
    e_lim = 126;
    drive(1, 1, C44, R22, MODE_XOR);
    wait_gnt(1);
    drive(1, 0, C44, R22, MODE_XOR);
    wait_done(1, 8'd0, 1, 1, 128);
    wait_idle();
    e_lim = 64;
    // req0 held high across back-to-back jobs
    drive(0, 1, C44, R22, MODE_AND);
    for (int i = 0; i < 3; i++) begin
      wait_gnt(0);
      if (i > 0) chk("b2b_gap", t_gnt - t0, 71);
      t0 = t_gnt;
      wait_done(0, 8'd8, 0, 1, 67);
    end
    drive(0, 0, C44, R22, MODE_AND);
    wait_idle();
    chk("operands_stable", unstable, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/set_arbiter.md
SET_ARBITER -- requirements
Module: set_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 127, max cycles to wait for eng_valid after issue before aborting the job.
REQ-002 clk  input  1  system clock, all flops rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0/req1  input  1 each  job request per requester; held high with operands stable until the matching gnt pulse.
REQ-005 central0/central1  input  24 each  circle centres {xA,yA,xB,yB,8'b0}.
REQ-006 radius0/radius1  input  12 each  radii {rA,rB,4'b0}.
REQ-007 mode0/mode1  input  2 each  set operation: 00 A, 01 A and B, 10 A xor B, 11 illegal.
REQ-008 gnt0/gnt1  output  1 each  one-cycle pulse: job accepted, operands captured.
REQ-009 done0/done1  output  1 each  one-cycle pulse: result0/result1 and err valid.
REQ-010 result0/result1  output  8 each  candidate count, held until that port's next done.
REQ-011 err  output  1  qualifies done: 1 on illegal mode or timeout.
REQ-012 eng_en  output  1  one-cycle start pulse to the set-count engine.
REQ-013 eng_central/eng_radius/eng_mode  output  24/12/2  engine operands, registered.
REQ-014 eng_busy/eng_valid/eng_candidate  input  1/1/8  engine status and count.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RUN, FINISH.
REQ-016 IDLE: when eng_busy==0 and any req is high, the arbiter SHALL select one port round-robin and go to ISSUE next cycle.
REQ-017 Round-robin: pointer resets to port 0; on both requesting, the pointer port wins; after each grant the pointer SHALL move to the other port.
REQ-018 ISSUE (one cycle): gnt of the selected port SHALL be 1, eng_en SHALL be 1 and eng_* operands SHALL equal the selected port's captured inputs; next state RUN.
REQ-019 eng_central/eng_radius/eng_mode SHALL hold constant from ISSUE until return to IDLE, because the engine samples mode every cycle.
REQ-020 RUN: on eng_valid==1, eng_candidate SHALL be latched into the selected port's result, and the FSM SHALL go to FINISH.
REQ-021 FINISH: done of the selected port SHALL pulse exactly once, on the first FINISH cycle; the FSM SHALL stay in FINISH until eng_busy==0, then go to IDLE.
REQ-022 Illegal mode 11 at selection SHALL bypass the engine: no eng_en, gnt plus done together in ISSUE, result 0, err 1, then go to IDLE.
REQ-023 Timeout: a 7-bit-minimum counter SHALL clear at ISSUE and increment in RUN; if it reaches TIMEOUT without eng_valid, result SHALL be 0 and err 1, and the FSM SHALL go to FINISH.
REQ-024 eng_valid arriving in the same cycle the counter reaches TIMEOUT SHALL take priority: normal result, err 0.
REQ-025 Requests arriving while not IDLE SHALL be held pending, never dropped, never granted twice.
REQ-026 A normal job with a conforming engine: gnt to done = 67 cycles (eng_en, 64 points, valid, capture).

Reset
REQ-027 On rst: state IDLE, pointer 0, gnt*/done*/err/eng_en 0, result*/eng_* 0, timeout counter 0.
REQ-028 rst mid-job SHALL abandon the job with no done; engine reset is the system's responsibility.

Structure
REQ-029 Shared package: state encoding, mode constants (MODE_A, MODE_AND, MODE_XOR, MODE_ILL), operand widths.
REQ-030 One sub-module is natural: set_rr_pick (2-way round-robin pick with pointer); the engine instance sits outside.

Verification
REQ-031 req0: centre A=(4,4), r=2, mode 00 -> gnt0, then done0 with result0=13, err=0, 67 cycles after gnt0.
REQ-032 req0 and req1 high in the same cycle after reset -> port 0 served first; gnt1 follows after eng_busy falls; pointer then favours 0.
REQ-033 req1 with mode 11 -> gnt1 and done1 in the same cycle, result1=0, err=1, eng_en never asserted.
REQ-034 Engine model that never raises valid, TIMEOUT=127 -> done0 with err=1, result0=0 after 127 RUN cycles.
REQ-035 rst raised at cycle 30 of RUN -> all outputs 0 at once; after release, a new req0 is served normally.
REQ-036 Back-to-back req0 held high -> each job is granted only after FINISH and eng_busy==0; eng_mode is stable throughout every RUN.
